program_loader: RTL and testbench

PROGRAM_LOADER -- requirements
Module: program_loader

---
 rtl/program_loader_if.sv | 28 ++
 rtl/program_loader.sv | 142 ++++++++++++++
 tb/tb_program_loader.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Program loader bus: byte stream in, program-memory write port and status out.
// The source side (byte producer / controller) uses the master modport,
// the loader itself uses the slave modport.
interface program_loader_if #(
   parameter int program_code_size = 8,
   parameter int instruction_size  = 24
);
   logic                         start;
   logic [7:0]                   byte_in;
   logic                         byte_valid;
   logic                         byte_ready;
   logic                         wr_en;
   logic [program_code_size-1:0] wr_address;
   logic [instruction_size-1:0]  wr_data;
   logic                         busy;
   logic                         done;
   logic                         error;

   modport master (
      output start, byte_in, byte_valid,
      input  byte_ready, wr_en, wr_address, wr_data, busy, done, error
   );

   modport slave (
      input  start, byte_in, byte_valid,
      output byte_ready, wr_en, wr_address, wr_data, busy, done, error
   );
endinterface

// File: rtl/program_loader.sv
// Program loader: assembles a serial byte stream (MSB-first) into instruction
// words and writes them to program memory from address 0 up to the last
// address, then stops.
// Optional feature macro: LOADER_CHECKSUM_EN -- after the last word one extra
// byte is taken and compared against the modulo-256 sum of all data bytes.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for start after reset
// S_RECV  | accepting bytes of the current word
// S_WRITE | one-cycle write strobe of the assembled word
// S_CHECK | accepting the checksum byte (LOADER_CHECKSUM_EN only)
// S_DONE  | load finished, waiting for a new start
module program_loader #(
   parameter int program_code_size = 8,
   parameter int instruction_size  = 24
) (
   input logic             clk,
   input logic             nReset,
   program_loader_if.slave bus
);
   localparam int NB    = (instruction_size + 7) / 8;
   localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [program_code_size-1:0] LAST_ADDR = {program_code_size{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE,
      S_RECV,
      S_WRITE,
      S_CHECK,
      S_DONE
   } state_t;

   state_t                        state_q, state_d;
   logic [program_code_size-1:0]  addr_q, addr_d;
   logic [IDX_W-1:0]              idx_q, idx_d;
   logic [instruction_size-1:0]   shreg_q, shreg_d;
   logic                          accept;

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] sum_q, sum_d;
   logic       error_q, error_d;
`endif

   assign bus.byte_ready = (state_q == S_RECV) || (state_q == S_CHECK);
   assign accept         = bus.byte_valid && bus.byte_ready;
   assign bus.wr_en      = (state_q == S_WRITE);
   assign bus.wr_address = addr_q;
   assign bus.wr_data    = shreg_q;
   assign bus.busy       = (state_q == S_RECV) || (state_q == S_WRITE) || (state_q == S_CHECK);
   assign bus.done       = (state_q == S_DONE);
`ifdef LOADER_CHECKSUM_EN
   assign bus.error      = error_q;
`else
   assign bus.error      = 1'b0;
`endif

   // State and datapath registers; reset also clears a partially received word.
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         idx_q   <= '0;
         shreg_q <= '0;
`ifdef LOADER_CHECKSUM_EN
         sum_q   <= '0;
         error_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
`ifdef LOADER_CHECKSUM_EN
         sum_q   <= sum_d;
         error_q <= error_d;
`endif
      end
   end

   // Next-state and datapath update; start is only honoured in IDLE and DONE.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
`ifdef LOADER_CHECKSUM_EN
      sum_d   = sum_q;
      error_d = error_q;
`endif
      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_d = S_RECV;
               addr_d  = '0;
               idx_d   = '0;
               shreg_d = '0;
`ifdef LOADER_CHECKSUM_EN
               sum_d   = '0;
               error_d = 1'b0;
`endif
            end
         end
         S_RECV: begin
            if (accept) begin
               // Truncation drops the excess high bits of the first byte.
               shreg_d = instruction_size'({shreg_q, bus.byte_in});
`ifdef LOADER_CHECKSUM_EN
               sum_d   = sum_q + bus.byte_in;
`endif
               if (idx_q == IDX_W'(NB - 1)) begin
                  idx_d   = '0;
                  state_d = S_WRITE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         S_WRITE: begin
            if (addr_q != LAST_ADDR) begin
               addr_d  = addr_q + program_code_size'(1);
               state_d = S_RECV;
            end else begin
`ifdef LOADER_CHECKSUM_EN
               state_d = S_CHECK;
`else
               state_d = S_DONE;
`endif
            end
         end
`ifdef LOADER_CHECKSUM_EN
         S_CHECK: begin
            if (accept) begin
               error_d = (bus.byte_in != sum_q);
               state_d = S_DONE;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader with program_code_size=2, instruction_size=24.
// A transaction-level model predicts handshake/status/write outputs every
// cycle; directed scenarios add literal expectations for the written words.
module tb_program_loader;
   localparam int PCS   = 2;
   localparam int ISZ   = 24;
   localparam int NB    = 3;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic nReset;

   program_loader_if #(.program_code_size(PCS), .instruction_size(ISZ)) bus ();

   program_loader #(.program_code_size(PCS), .instruction_size(ISZ)) dut (
      .clk    (clk),
      .nReset (nReset),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   logic [7:0]  prog  [0:11];
   logic [23:0] exp_w [0:3];
   logic [7:0]  cks;

   logic [PCS-1:0] log_addr [$];
   logic [ISZ-1:0] log_data [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Transaction-level model: words, address and phase flags, not RTL states.
   bit             m_active = 0;
   bit             m_done   = 0;
   bit             m_err    = 0;
   bit             m_chk    = 0;
   bit             m_wr     = 0;
   int             m_cnt    = 0;
   int             m_addr   = 0;
   logic [23:0]    m_word   = '0;
   logic [7:0]     m_sum    = '0;

   always @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         m_active = 0; m_done = 0; m_err = 0; m_chk = 0; m_wr = 0;
         m_cnt = 0; m_addr = 0; m_word = '0; m_sum = '0;
      end else if (m_wr) begin
         m_wr = 0;
         if (m_addr == DEPTH - 1) begin
`ifdef LOADER_CHECKSUM_EN
            m_chk = 1;
`else
            m_active = 0;
            m_done   = 1;
`endif
         end else begin
            m_addr++;
         end
      end else if (m_active && bus.byte_valid) begin
         if (m_chk) begin
            m_err    = (bus.byte_in != m_sum);
            m_chk    = 0;
            m_active = 0;
            m_done   = 1;
         end else begin
            m_word = {m_word[15:0], bus.byte_in};
            m_sum  = m_sum + bus.byte_in;
            m_cnt++;
            if (m_cnt == NB) begin
               m_cnt = 0;
               m_wr  = 1;
            end
         end
      end else if (!m_active && bus.start) begin
         m_active = 1; m_done = 0; m_err = 0; m_addr = 0;
         m_cnt = 0; m_word = '0; m_sum = '0;
      end
   end

   // Compare process: every cycle, away from the active edge.
   always @(negedge clk) begin
      chk("byte_ready", 32'(bus.byte_ready), 32'(m_active && !m_wr));
      chk("wr_en",      32'(bus.wr_en),      32'(m_wr));
      chk("busy",       32'(bus.busy),       32'(m_active));
      chk("done",       32'(bus.done),       32'(m_done));
      chk("error",      32'(bus.error),      32'(m_err));
      if (m_wr) begin
         chk("wr_address", 32'(bus.wr_address), 32'(m_addr));
         chk("wr_data",    32'(bus.wr_data),    32'(m_word));
      end
      if (!nReset) begin
         chk("rst_wr_address", 32'(bus.wr_address), 32'h0);
         chk("rst_wr_data",    32'(bus.wr_data),    32'h0);
      end
      if (bus.wr_en) begin
         log_addr.push_back(bus.wr_address);
         log_data.push_back(bus.wr_data);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic send_one(input logic [7:0] b, input bit gap);
      logic acc;
      acc = 1'b0;
      bus.byte_in    = b;
      bus.byte_valid = 1'b1;
      for (int k = 0; k < 50 && !acc; k++) begin
         @(negedge clk);
         acc = bus.byte_ready;
         tick();
      end
      if (!acc) chk("accept_timeout", 32'(acc), 32'h1);
      bus.byte_valid = 1'b0;
      if (gap) tick();
   endtask

   task automatic send_range(input int first, input int n, input bit gap);
      for (int i = first; i < first + n; i++) send_one(prog[i], gap);
   endtask

   task automatic wait_done();
      for (int k = 0; k < 40 && !bus.done; k++) @(negedge clk);
      chk("wait_done", 32'(bus.done), 32'h1);
      tick();
   endtask

   task automatic finish_load();
`ifdef LOADER_CHECKSUM_EN
      send_one(cks, 1'b0);
`endif
      wait_done();
   endtask

   task automatic check_log(input string tag);
      chk({tag, "_nwrites"}, 32'(log_addr.size()), 32'd4);
      for (int i = 0; i < log_addr.size() && i < 4; i++) begin
         chk({tag, "_addr"}, 32'(log_addr[i]), 32'(i));
         chk({tag, "_data"}, 32'(log_data[i]), 32'(exp_w[i]));
      end
   endtask

   initial begin
      prog  = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF,
                8'h00, 8'h11, 8'h22, 8'hFF, 8'hEE, 8'hDD};
      exp_w = '{24'h123456, 24'hABCDEF, 24'h001122, 24'hFFEEDD};
      cks   = 8'h00;
      for (int i = 0; i < 12; i++) cks = cks + prog[i];

      bus.start      = 1'b0;
      bus.byte_in    = 8'h00;
      bus.byte_valid = 1'b0;
      nReset         = 1'b1;
      #2 nReset      = 1'b0;
      repeat (3) tick();
      nReset = 1'b1;
      repeat (3) tick();
      chk("idle_busy",  32'(bus.busy),       32'h0);
      chk("idle_ready", 32'(bus.byte_ready), 32'h0);
      chk("idle_done",  32'(bus.done),       32'h0);

      // Continuous full load.
      log_addr.delete(); log_data.delete();
      pulse_start();
      chk("start_busy", 32'(bus.busy), 32'h1);
      send_range(0, 12, 1'b0);
      finish_load();
      check_log("full");
      chk("full_done", 32'(bus.done), 32'h1);
      chk("full_busy", 32'(bus.busy), 32'h0);

      // Back-pressure, restarted from DONE.
      log_addr.delete(); log_data.delete();
      pulse_start();
      chk("restart_done", 32'(bus.done), 32'h0);
      chk("restart_busy", 32'(bus.busy), 32'h1);
      send_range(0, 12, 1'b1);
      finish_load();
      check_log("bp");

      // start while busy (in WRITE and mid-word in RECV) must be ignored.
      log_addr.delete(); log_data.delete();
      pulse_start();
      send_range(0, 3, 1'b0);
      pulse_start();
      send_range(3, 2, 1'b0);
      pulse_start();
      send_range(5, 7, 1'b0);
      finish_load();
      check_log("ctl");

`ifdef LOADER_CHECKSUM_EN
      pulse_start();
      send_range(0, 12, 1'b0);
      send_one(cks + 8'h01, 1'b0);
      wait_done();
      chk("cks_bad_error", 32'(bus.error), 32'h1);
      chk("cks_bad_done",  32'(bus.done),  32'h1);
      pulse_start();
      chk("cks_clear_error", 32'(bus.error), 32'h0);
      send_range(0, 12, 1'b0);
      send_one(cks, 1'b0);
      wait_done();
      chk("cks_ok_error", 32'(bus.error), 32'h0);
`endif

      // Reset mid-word.
      pulse_start();
      send_range(0, 2, 1'b0);
      nReset = 1'b0;
      #1;
      chk("rst_ready",   32'(bus.byte_ready), 32'h0);
      chk("rst_wr_en",   32'(bus.wr_en),      32'h0);
      chk("rst_addr",    32'(bus.wr_address), 32'h0);
      chk("rst_data",    32'(bus.wr_data),    32'h0);
      chk("rst_busy",    32'(bus.busy),       32'h0);
      chk("rst_done",    32'(bus.done),       32'h0);
      chk("rst_error",   32'(bus.error),      32'h0);
      repeat (2) tick();
      nReset = 1'b1;
      repeat (2) tick();
      chk("post_rst_busy",  32'(bus.busy),       32'h0);
      chk("post_rst_ready", 32'(bus.byte_ready), 32'h0);
      log_addr.delete(); log_data.delete();
      pulse_start();
      send_one(8'h9A, 1'b0);
      send_one(8'hBC, 1'b0);
      send_one(8'hDE, 1'b0);
      repeat (2) tick();
      chk("rst_nwrites", 32'(log_addr.size()), 32'h1);
      if (log_addr.size() > 0) begin
         chk("rst_first_addr", 32'(log_addr[0]), 32'h0);
         chk("rst_first_data", 32'(log_data[0]), 32'h9ABCDE);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
